operand_fetch_unit: RTL and testbench

- Requester side of the register file read ports. It accepts one decoded instruction at a time and checks a per-register busy scoreboard for hazards.
- Once clear, it drives the register file primary/secondary read enables and addresses, then captures the registered read data one cycle later.
- It presents the operand pair to a functional unit over a valid/ready handshake, and marks the destination busy until writeback reports completion.

---
 rtl/operand_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_operand_fetch_unit.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_unit.sv
// operand_fetch_unit: scoreboarded register-file operand fetch feeding a functional unit.
// Optional feature macro OPFETCH_STALL_COUNT_EN adds the stallCount_o hazard-stall counter.
module operand_fetch_unit #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 16,
    parameter int OPC_W    = 8
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              instValid_i,
    output logic              instReady_o,
    input  logic [OPC_W-1:0]  instOpcode_i,
    input  logic [4:0]        instDest_i,
    input  logic              instWritesDest_i,
    input  logic [4:0]        instPrimAddr_i,
    input  logic [DATA_W-1:0] instSec_i,
    input  logic              instSecIsReg_i,
    output logic              rfPrimEnable_o,
    output logic [4:0]        rfPrimAddr_o,
    input  logic [DATA_W-1:0] rfPrimData_i,
    output logic              rfSecEnable_o,
    output logic              rfSecIsReg_o,
    output logic [DATA_W-1:0] rfSecAddr_o,
    input  logic [DATA_W-1:0] rfSecData_i,
    input  logic              wbValid_i,
    input  logic [4:0]        wbAddr_i,
    output logic              opValid_o,
    input  logic              opReady_i,
    output logic [OPC_W-1:0]  opOpcode_o,
    output logic [4:0]        opDest_o,
    output logic              opWritesDest_o,
    output logic [DATA_W-1:0] opA_o,
    output logic [DATA_W-1:0] opB_o
`ifdef OPFETCH_STALL_COUNT_EN
    ,
    output logic [15:0]       stallCount_o
`endif
);

    typedef enum logic [1:0] {IDLE, CHECK, CAPTURE, OUTPUT} state_t;

    state_t              state;
    logic [OPC_W-1:0]    hold_opcode;
    logic [4:0]          hold_dest;
    logic                hold_writes_dest;
    logic [4:0]          hold_prim;
    logic [DATA_W-1:0]   hold_sec;
    logic                hold_sec_is_reg;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic [31:0]         busy_ext;
    logic                hazard;
    logic                issue;

    // Widened view so any 5-bit address indexes safely; untracked regs read as free.
    always_comb begin
        busy_ext = '0;
        for (int i = 0; i < NUM_REGS; i++) busy_ext[i] = busy[i];
    end

    assign hazard = busy_ext[hold_prim]
                  | (hold_sec_is_reg & busy_ext[hold_sec[4:0]])
                  | (hold_writes_dest & busy_ext[hold_dest]);

    assign issue          = !reset_i && (state == CHECK) && !hazard;
    assign instReady_o    = !reset_i && (state == IDLE);
    assign rfPrimEnable_o = issue;
    assign rfSecEnable_o  = issue;
    assign rfSecIsReg_o   = issue & hold_sec_is_reg;
    assign rfPrimAddr_o   = issue ? hold_prim : 5'd0;
    assign rfSecAddr_o    = issue ? hold_sec : '0;

    // Writeback clear first, capture set second, so the set wins on a collision.
    always_comb begin
        busy_next = busy;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wbValid_i && wbAddr_i == 5'(i)) busy_next[i] = 1'b0;
            if (state == CAPTURE && hold_writes_dest && hold_dest == 5'(i))
                busy_next[i] = 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state            <= IDLE;
            busy             <= '0;
            hold_opcode      <= '0;
            hold_dest        <= '0;
            hold_writes_dest <= 1'b0;
            hold_prim        <= '0;
            hold_sec         <= '0;
            hold_sec_is_reg  <= 1'b0;
            opValid_o        <= 1'b0;
            opOpcode_o       <= '0;
            opDest_o         <= '0;
            opWritesDest_o   <= 1'b0;
            opA_o            <= '0;
            opB_o            <= '0;
        end else begin
            busy <= busy_next;
            unique case (state)
                IDLE: begin
                    if (instValid_i) begin
                        hold_opcode      <= instOpcode_i;
                        hold_dest        <= instDest_i;
                        hold_writes_dest <= instWritesDest_i;
                        hold_prim        <= instPrimAddr_i;
                        hold_sec         <= instSec_i;
                        hold_sec_is_reg  <= instSecIsReg_i;
                        state            <= CHECK;
                    end
                end
                CHECK: begin
                    if (!hazard) state <= CAPTURE;
                end
                CAPTURE: begin
                    opA_o          <= rfPrimData_i;
                    opB_o          <= rfSecData_i;
                    opOpcode_o     <= hold_opcode;
                    opDest_o       <= hold_dest;
                    opWritesDest_o <= hold_writes_dest;
                    opValid_o      <= 1'b1;
                    state          <= OUTPUT;
                end
                OUTPUT: begin
                    if (opReady_i) begin
                        opValid_o <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef OPFETCH_STALL_COUNT_EN
    always_ff @(posedge clock_i) begin
        if (reset_i)
            stallCount_o <= '0;
        else if (state == CHECK && hazard && stallCount_o != 16'hFFFF)
            stallCount_o <= stallCount_o + 16'd1;
    end
`endif

endmodule

// File: tb/tb_operand_fetch_unit.sv
// tb_operand_fetch_unit: directed bench with a transaction-level reference model.
// Builds with or without OPFETCH_STALL_COUNT_EN.
module tb_operand_fetch_unit;

    localparam int NR = 16;
    localparam int DW = 16;
    localparam int OW = 8;

    logic          clock_i = 1'b0;
    logic          reset_i;
    logic          instValid_i;
    logic          instReady_o;
    logic [OW-1:0] instOpcode_i;
    logic [4:0]    instDest_i;
    logic          instWritesDest_i;
    logic [4:0]    instPrimAddr_i;
    logic [DW-1:0] instSec_i;
    logic          instSecIsReg_i;
    logic          rfPrimEnable_o;
    logic [4:0]    rfPrimAddr_o;
    logic [DW-1:0] rfPrimData_i;
    logic          rfSecEnable_o;
    logic          rfSecIsReg_o;
    logic [DW-1:0] rfSecAddr_o;
    logic [DW-1:0] rfSecData_i;
    logic          wbValid_i;
    logic [4:0]    wbAddr_i;
    logic          opValid_o;
    logic          opReady_i;
    logic [OW-1:0] opOpcode_o;
    logic [4:0]    opDest_o;
    logic          opWritesDest_o;
    logic [DW-1:0] opA_o;
    logic [DW-1:0] opB_o;
`ifdef OPFETCH_STALL_COUNT_EN
    logic [15:0]   stallCount_o;
`endif

    operand_fetch_unit #(.NUM_REGS(NR), .DATA_W(DW), .OPC_W(OW)) dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .instValid_i(instValid_i), .instReady_o(instReady_o),
        .instOpcode_i(instOpcode_i), .instDest_i(instDest_i),
        .instWritesDest_i(instWritesDest_i), .instPrimAddr_i(instPrimAddr_i),
        .instSec_i(instSec_i), .instSecIsReg_i(instSecIsReg_i),
        .rfPrimEnable_o(rfPrimEnable_o), .rfPrimAddr_o(rfPrimAddr_o),
        .rfPrimData_i(rfPrimData_i), .rfSecEnable_o(rfSecEnable_o),
        .rfSecIsReg_o(rfSecIsReg_o), .rfSecAddr_o(rfSecAddr_o),
        .rfSecData_i(rfSecData_i), .wbValid_i(wbValid_i), .wbAddr_i(wbAddr_i),
        .opValid_o(opValid_o), .opReady_i(opReady_i),
        .opOpcode_o(opOpcode_o), .opDest_o(opDest_o),
        .opWritesDest_o(opWritesDest_o), .opA_o(opA_o), .opB_o(opB_o)
`ifdef OPFETCH_STALL_COUNT_EN
        , .stallCount_o(stallCount_o)
`endif
    );

    always #5 clock_i = ~clock_i;

    int nvec = 0;
    int nerr = 0;
    logic [DW-1:0] regs [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Register file: registered read, immediate echoed back on the secondary port.
    always @(posedge clock_i) begin
        if (rfPrimEnable_o) rfPrimData_i <= regs[rfPrimAddr_o];
        if (rfSecEnable_o)
            rfSecData_i <= rfSecIsReg_o ? regs[rfSecAddr_o[4:0]] : rfSecAddr_o;
    end

    // Reference model: 0 waiting, 1 checking, 2 fetching, 3 presenting.
    int            m_ph = 0;
    bit            m_busy [32];
    int            m_stall = 0;
    logic          m_opv = 1'b0;
    logic [DW-1:0] m_a = '0, m_b = '0;
    logic [OW-1:0] m_opc = '0;
    logic [4:0]    m_dest = '0;
    logic          m_wd = 1'b0;
    logic [OW-1:0] i_opc = '0;
    logic [4:0]    i_dest = '0, i_prim = '0;
    logic          i_wd = 1'b0, i_sr = 1'b0;
    logic [DW-1:0] i_sec = '0;

    function automatic bit m_haz();
        return m_busy[i_prim] || (i_sr && m_busy[i_sec[4:0]]) || (i_wd && m_busy[i_dest]);
    endfunction

    always @(posedge clock_i) begin
        bit haz;
        int ph;
        haz = m_haz();
        ph  = m_ph;
        if (reset_i) begin
            m_ph = 0; m_stall = 0; m_opv = 0;
            m_a = '0; m_b = '0; m_opc = '0; m_dest = '0; m_wd = 0;
            i_opc = '0; i_dest = '0; i_prim = '0; i_wd = 0; i_sr = 0; i_sec = '0;
            for (int k = 0; k < 32; k++) m_busy[k] = 0;
        end else begin
            if (ph == 1 && haz && m_stall < 65535) m_stall++;
            case (ph)
                0: if (instValid_i) begin
                    i_opc = instOpcode_i; i_dest = instDest_i; i_wd = instWritesDest_i;
                    i_prim = instPrimAddr_i; i_sec = instSec_i; i_sr = instSecIsReg_i;
                    m_ph = 1;
                end
                1: if (!haz) m_ph = 2;
                2: begin
                    m_a = regs[i_prim];
                    m_b = i_sr ? regs[i_sec[4:0]] : i_sec;
                    m_opc = i_opc; m_dest = i_dest; m_wd = i_wd;
                    m_opv = 1; m_ph = 3;
                end
                default: if (opReady_i) begin m_opv = 0; m_ph = 0; end
            endcase
            if (wbValid_i && wbAddr_i < NR) m_busy[wbAddr_i] = 0;
            if (ph == 2 && i_wd && i_dest < NR) m_busy[i_dest] = 1;
        end
    end

    always @(negedge clock_i) begin
        bit en;
        en = !reset_i && m_ph == 1 && !m_haz();
        chk("instReady", instReady_o, !reset_i && m_ph == 0);
        chk("rfPrimEnable", rfPrimEnable_o, en);
        chk("rfSecEnable", rfSecEnable_o, en);
        if (en) chk("rfSecIsReg", rfSecIsReg_o, i_sr);
        chk("rfPrimAddr", rfPrimAddr_o, en ? i_prim : 5'd0);
        chk("rfSecAddr", rfSecAddr_o, en ? i_sec : 16'd0);
        chk("opValid", opValid_o, m_opv);
        chk("opA", opA_o, m_a);
        chk("opB", opB_o, m_b);
        chk("opOpcode", opOpcode_o, m_opc);
        chk("opDest", opDest_o, m_dest);
        chk("opWritesDest", opWritesDest_o, m_wd);
`ifdef OPFETCH_STALL_COUNT_EN
        chk("stallCount", stallCount_o, m_stall);
`endif
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock_i);
    endtask

    task automatic issue(input logic [7:0] opc, input logic [4:0] dest, input logic wd,
                         input logic [4:0] prim, input logic [15:0] sec, input logic sr);
        int n = 0;
        while (instReady_o !== 1'b1 && n < 50) begin @(negedge clock_i); n++; end
        chk("issue_ready", instReady_o, 1);
        #1;
        instValid_i = 1; instOpcode_i = opc; instDest_i = dest;
        instWritesDest_i = wd; instPrimAddr_i = prim; instSec_i = sec; instSecIsReg_i = sr;
        @(negedge clock_i);
        #1 instValid_i = 0;
    endtask

    task automatic wait_valid(input int max);
        int n = 0;
        while (opValid_o !== 1'b1 && n < max) begin @(negedge clock_i); n++; end
        chk("opValid_wait", opValid_o, 1);
    endtask

    task automatic finish_op();
        wait_valid(20);
        #1 opReady_i = 1;
        @(negedge clock_i);
        chk("op_done", opValid_o, 0);
        #1 opReady_i = 0;
    endtask

    task automatic wb(input logic [4:0] a);
        @(negedge clock_i);
        #1 wbValid_i = 1; wbAddr_i = a;
        @(negedge clock_i);
        #1 wbValid_i = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        reset_i = 1; instValid_i = 0; instOpcode_i = '0; instDest_i = '0;
        instWritesDest_i = 0; instPrimAddr_i = '0; instSec_i = '0; instSecIsReg_i = 0;
        wbValid_i = 0; wbAddr_i = '0; opReady_i = 0;
        for (int i = 0; i < 32; i++) regs[i] = 16'h1000 + 16'(i) * 16'h0101;
        regs[3] = 16'h1234;
        regs[5] = 16'h00AB;
        cyc(3);
        chk("rst_instReady", instReady_o, 0);
        chk("rst_opValid", opValid_o, 0);
        #1 reset_i = 0;
        cyc(1);
        chk("idle_ready", instReady_o, 1);

        issue(8'hA5, 5'd7, 1, 5'd3, 16'h0005, 1);
        chk("t1_primEn", rfPrimEnable_o, 1);
        chk("t1_primAddr", rfPrimAddr_o, 3);
        chk("t1_secAddr", rfSecAddr_o, 5);
        chk("t1_ready_low", instReady_o, 0);
        cyc(1);
        chk("t1_en_pulse", rfPrimEnable_o, 0);
        chk("t1_opv_early", opValid_o, 0);
        cyc(1);
        chk("t1_opv", opValid_o, 1);
        chk("t1_opA", opA_o, 16'h1234);
        chk("t1_opB", opB_o, 16'h00AB);
        chk("t1_dest", opDest_o, 7);
        chk("t1_opc", opOpcode_o, 8'hA5);
        finish_op();

        issue(8'h11, 5'd8, 1, 5'd7, 16'h0000, 0);
        repeat (4) begin chk("raw_stall", rfPrimEnable_o, 0); cyc(1); end
        chk("raw_pre_wb", rfPrimEnable_o, 0);
        #1 wbValid_i = 1; wbAddr_i = 5'd7;
        cyc(1);
        chk("raw_release", rfPrimEnable_o, 1);
        #1 wbValid_i = 0;
        wait_valid(10);
        chk("raw_opA", opA_o, 16'h1707);
        finish_op();
        wb(5'd8);

        issue(8'h22, 5'd15, 1, 5'd1, 16'hBEEF, 0);
        chk("imm_en", rfSecEnable_o, 1);
        chk("imm_isreg", rfSecIsReg_o, 0);
        chk("imm_addr", rfSecAddr_o, 16'hBEEF);
        wait_valid(10);
        chk("imm_opB", opB_o, 16'hBEEF);
        finish_op();
        wb(5'd15);

        issue(8'h33, 5'd9, 0, 5'd2, 16'h0006, 1);
        wait_valid(10);
        repeat (5) begin
            chk("bp_valid", opValid_o, 1);
            chk("bp_opA", opA_o, 16'h1202);
            chk("bp_opB", opB_o, 16'h1606);
            chk("bp_opc", opOpcode_o, 8'h33);
            chk("bp_ready", instReady_o, 0);
            cyc(1);
        end
        #1 opReady_i = 1;
        cyc(1);
        chk("bp_done", opValid_o, 0);
        chk("bp_idle", instReady_o, 1);
        #1 opReady_i = 0;

        issue(8'h66, 5'd20, 1, 5'd0, 16'h0003, 0);
        finish_op();
        issue(8'h67, 5'd20, 1, 5'd20, 16'h0014, 1);
        chk("oor_no_hazard", rfPrimEnable_o, 1);
        finish_op();

        cyc(1);
        #1 reset_i = 1;
        cyc(1);
        #1 reset_i = 0;
        issue(8'h44, 5'd2, 1, 5'd0, 16'h0001, 0);
        finish_op();
        issue(8'h45, 5'd2, 1, 5'd0, 16'h0001, 0);
        repeat (6) begin chk("waw_stall", rfPrimEnable_o, 0); cyc(1); end
`ifdef OPFETCH_STALL_COUNT_EN
        chk("stall6", stallCount_o, 6);
`endif
        wb(5'd2);
        finish_op();
        wb(5'd2);

        issue(8'h55, 5'd4, 1, 5'd0, 16'h0002, 0);
        chk("sim_issue", rfPrimEnable_o, 1);
        cyc(1);
        #1 wbValid_i = 1; wbAddr_i = 5'd4;
        cyc(1);
        #1 wbValid_i = 0;
        finish_op();
        issue(8'h56, 5'd10, 0, 5'd4, 16'h0000, 0);
        repeat (3) begin chk("sim_set_wins", rfPrimEnable_o, 0); cyc(1); end
        wb(5'd4);
        finish_op();

        issue(8'h77, 5'd11, 1, 5'd0, 16'h0000, 0);
        finish_op();
        issue(8'h78, 5'd0, 0, 5'd11, 16'h0000, 0);
        cyc(1);
        chk("rc_stalled", rfPrimEnable_o, 0);
        #1 reset_i = 1;
        cyc(1);
        chk("rc_opv", opValid_o, 0);
        chk("rc_ready_rst", instReady_o, 0);
        #1 reset_i = 0;
        cyc(1);
        chk("rc_idle", instReady_o, 1);
        issue(8'h79, 5'd0, 0, 5'd11, 16'h0000, 0);
        chk("rc_busy_cleared", rfPrimEnable_o, 1);
        finish_op();

        issue(8'h88, 5'd12, 1, 5'd6, 16'h0000, 0);
        wait_valid(10);
        #1 reset_i = 1;
        cyc(1);
        chk("ro_opv", opValid_o, 0);
        chk("ro_opA", opA_o, 0);
        #1 reset_i = 0;
        issue(8'h89, 5'd0, 0, 5'd12, 16'h0000, 0);
        chk("ro_busy_cleared", rfPrimEnable_o, 1);
        finish_op();
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
